dvp_rgb565_capture: RTL and testbench
=====================================

# dvp_rgb565_capture

Front-end capture stage that converts the camera's 8-bit DVP byte stream (vsync/href/data) into the 16-bit RGB565 pixel stream with hs/vs/clken qualifiers consumed by the image-processing chain (Gaussian filter → HSV histogram → mark-out). It discards sensor settling frames after reset and only admits whole frames. It reports per-frame geometry errors and pixel coordinates so the tracker's px/py outputs refer to a known frame geometry.

## Interface
Parameters:
- H_ACTIVE, 640: expected pixels per line.
- V_ACTIVE, 480: expected lines per frame.
- SKIP_FRAMES, 10: frames discarded after reset (≥1).

Ports:
- clk  input  1  camera pixel clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cam_vsync  input  1  sensor vsync, high = vertical blanking pulse.
- cam_href  input  1  sensor line valid, high during active bytes.
- cam_data  input  8  sensor byte, high byte of RGB565 first.
- capture_en  input  1  frame admission enable, sampled only at frame start.
- post_hs  output  1  line active, aligned to post_clken.
- post_vs  output  1  frame active, high for the whole admitted frame.
- post_clken  output  1  one-cycle pixel strobe.
- post_imgdata  output  16  RGB565 pixel, valid when post_clken=1.
- px_x  output  12  column of the current pixel, valid with post_clken.
- px_y  output  12  row of the current pixel, valid with post_clken.
- frame_done  output  1  one-cycle pulse at the end of an admitted frame.
- frame_err  output  1  geometry error flag for the last admitted frame, updated with frame_done.

## Operation
- Input register stage: cam_vsync, cam_href, and cam_data are registered once (s1_*). All decisions use the s1 signals.
- Edge detect on s1_vsync:
  - rise = frame end / blanking start.
  - fall = frame start.
- FSM states:
  - SKIP: count rises; after SKIP_FRAMES rises go to WAIT.
  - WAIT: on fall with capture_en=1 go to ACTIVE; capture_en=0 stays in WAIT.
  - ACTIVE: pass pixels; on rise pulse frame_done and go to WAIT.
- capture_en is ignored inside ACTIVE, so frames are never truncated.
- Byte phase:
  - Cleared whenever s1_href=0.
  - Toggles on each s1_href=1 cycle in ACTIVE.
  - Phase 0 latches hi=s1_data.
  - Phase 1 outputs post_imgdata={hi,s1_data} with post_clken=1.
- Column counter x:
  - Holds the column index of the pixel being output; increments after each pixel.
  - Cleared on s1_href fall.
  - Saturates at 4095.
- Row counter y:
  - Increments on s1_href fall if the line produced ≥1 pixel.
  - Cleared on frame start; saturates at 4095.
- Error accumulator err_acc (cleared at frame start) is set when any of these occurs:
  - On s1_href fall: x≠H_ACTIVE, or the phase is 1 (odd byte count; the dangling byte is dropped).
  - At frame end: y≠V_ACTIVE.
  - s1_vsync=1 while s1_href=1 in ACTIVE.
- At frame end, frame_err←err_acc (including the final row check) in the same cycle as the frame_done pulse.
- post_hs = s1_href delayed one cycle, gated by ACTIVE.
- post_vs:
  - Set in the cycle after entering ACTIVE.
  - Cleared in the frame_done cycle.
- px_x/px_y: registered copies of x/y, sampled with each pixel.
- Reset values: all outputs 0; state SKIP; counters, phase, hi, and err_acc 0.

## Timing
- Byte pair at cam_data on rising edges k (hi) and k+1 (lo) → post_clken=1 during the cycle after edge k+2; fixed latency of 2 cycles from the lo byte.
- Back-to-back pixels: post_clken at most every 2nd cycle; never two consecutive cycles.
- frame_done: exactly one cycle, in the cycle after s1_vsync rises (edge+2 from cam_vsync). post_vs falls on the same edge.
- Frame start: cam_vsync fall at edge k → ACTIVE from edge k+2 → post_vs=1 from edge k+3.
- Reset asserted mid-frame: all outputs 0 asynchronously; FSM restarts in SKIP, and SKIP_FRAMES complete frames are dropped again.
- A vsync rise coinciding with the href fall: the line check is applied first, then the frame check; both feed the same frame_err.

## Test plan
- Params H_ACTIVE=4, V_ACTIVE=2, SKIP_FRAMES=1, capture_en=1; drive 2 clean frames.
  - Frame 1: no post_clken.
  - Frame 2: exactly 8 post_clken; px_x 0..3, px_y 0..1; frame_done once; frame_err=0.
- Byte pair 0xF8,0x1F → post_imgdata=0xF81F exactly 2 cycles after the lo byte; post_hs=1 with it; px_x=0.
- Line of 7 bytes (3 pixels + odd byte) in an otherwise valid frame → 3 strobes on that line; last byte dropped; frame_err=1 at frame_done.
- capture_en=0 asserted mid-frame → current frame completes with 8 pixels and frame_done; next frame produces no strobes and post_vs stays 0. Re-enabling capture_en admits the following frame.
- rst pulsed on 2nd pixel of an active frame → outputs 0 immediately; the next sensor frame is skipped; output resumes on the one after.
- Frame with 3 lines (V mismatch) → 12 strobes, px_y reaches 2, frame_err=1. The following clean frame → frame_err=0.

Source files
------------

// File: rtl/dvp_rgb565_capture.sv
// DVP byte stream to RGB565 pixel stream with frame admission, coordinates and geometry checks.
// Latency: pixel strobe 2 clk after the low byte is sampled; frame_done 2 clk after cam_vsync rises.
// Backpressure: none; the sensor cannot be stalled, so pixels are strobed as they arrive.
module dvp_rgb565_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_en,
    output logic        post_hs,
    output logic        post_vs,
    output logic        post_clken,
    output logic [15:0] post_imgdata,
    output logic [11:0] px_x,
    output logic [11:0] px_y,
    output logic        frame_done,
    output logic        frame_err
);
    localparam int                SKIP_W    = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES - 1);
    localparam logic [11:0]       H_EXP     = 12'(H_ACTIVE);
    localparam logic [11:0]       V_EXP     = 12'(V_ACTIVE);

    typedef enum logic [1:0] {ST_SKIP, ST_WAIT, ST_ACTIVE} state_t;

    state_t            state;
    logic              s1_vsync, s1_href, s1_vsync_d, s1_href_d;
    logic [7:0]        s1_data, hi;
    logic              phase, armed, err_acc;
    logic [SKIP_W-1:0] skip_cnt;
    logic [11:0]       x, y;

    logic              vs_rise, vs_fall, hr_fall, line_err, err_now;
    logic [11:0]       x_inc, y_line;

    // The line check is folded into y_line/err_now so a vsync rise on the
    // same cycle as an href fall sees the completed line.
    always_comb begin
        vs_rise  = s1_vsync & ~s1_vsync_d;
        vs_fall  = ~s1_vsync & s1_vsync_d;
        hr_fall  = s1_href_d & ~s1_href;
        x_inc    = (x == 12'hFFF) ? x : x + 12'd1;
        y_line   = y;
        if (hr_fall && x != 12'd0 && y != 12'hFFF)
            y_line = y + 12'd1;
        line_err = hr_fall & ((x != H_EXP) | phase);
        err_now  = err_acc | line_err | (s1_vsync & s1_href);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_SKIP;
            s1_vsync     <= 1'b0;
            s1_href      <= 1'b0;
            s1_data      <= 8'd0;
            s1_vsync_d   <= 1'b0;
            s1_href_d    <= 1'b0;
            hi           <= 8'd0;
            phase        <= 1'b0;
            armed        <= 1'b0;
            err_acc      <= 1'b0;
            skip_cnt     <= '0;
            x            <= 12'd0;
            y            <= 12'd0;
            post_hs      <= 1'b0;
            post_vs      <= 1'b0;
            post_clken   <= 1'b0;
            post_imgdata <= 16'd0;
            px_x         <= 12'd0;
            px_y         <= 12'd0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            s1_vsync   <= cam_vsync;
            s1_href    <= cam_href;
            s1_data    <= cam_data;
            s1_vsync_d <= s1_vsync;
            s1_href_d  <= s1_href;
            post_clken <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                // Only rises preceded by a fall count, so a frame cut short by
                // reset is never mistaken for a whole settling frame.
                ST_SKIP: begin
                    post_hs <= 1'b0;
                    post_vs <= 1'b0;
                    phase   <= 1'b0;
                    if (vs_fall)
                        armed <= 1'b1;
                    if (vs_rise && armed) begin
                        if (skip_cnt == SKIP_LAST)
                            state <= ST_WAIT;
                        else
                            skip_cnt <= skip_cnt + SKIP_W'(1);
                    end
                end

                ST_WAIT: begin
                    post_hs <= 1'b0;
                    post_vs <= 1'b0;
                    phase   <= 1'b0;
                    if (vs_fall && capture_en) begin
                        state   <= ST_ACTIVE;
                        x       <= 12'd0;
                        y       <= 12'd0;
                        err_acc <= 1'b0;
                    end
                end

                ST_ACTIVE: begin
                    post_hs <= s1_href;
                    post_vs <= 1'b1;
                    err_acc <= err_now;
                    if (s1_href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi <= s1_data;
                        end else begin
                            post_clken   <= 1'b1;
                            post_imgdata <= {hi, s1_data};
                            px_x         <= x;
                            px_y         <= y;
                            x            <= x_inc;
                        end
                    end else begin
                        phase <= 1'b0;
                    end
                    if (hr_fall) begin
                        x <= 12'd0;
                        y <= y_line;
                    end
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_err  <= err_now | (y_line != V_EXP);
                        post_vs    <= 1'b0;
                        post_hs    <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end

                default: state <= ST_SKIP;
            endcase
        end
    end
endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed frame table plus hand sequences for latency and mid-frame reset.
module tb_dvp_rgb565_capture;
    logic        clk = 1'b0;
    logic        rst, cam_vsync, cam_href, capture_en;
    logic [7:0]  cam_data;
    logic        post_hs, post_vs, post_clken, frame_done, frame_err;
    logic [15:0] post_imgdata;
    logic [11:0] px_x, px_y;

    dvp_rgb565_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(1)) dut (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .post_hs(post_hs),
        .post_vs(post_vs), .post_clken(post_clken), .post_imgdata(post_imgdata),
        .px_x(px_x), .px_y(px_y), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      nl;
        logic [3:0][3:0] lb;
        logic            en;
        logic            admit;
        logic            err;
        logic            probe;
        logic            drop0;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] act_q[$];
    logic [39:0] exp_q[$];
    int          done_cnt, consec_bad, hs_bad, line_seed;
    bit          vs_seen, prev_clken;

    always @(negedge clk) begin
        if (post_clken) act_q.push_back({post_imgdata, px_x, px_y});
        if (post_clken && prev_clken) consec_bad++;
        if (post_clken && !post_hs) hs_bad++;
        prev_clken = post_clken;
        if (frame_done) done_cnt++;
        if (post_vs) vs_seen = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int nl, input int a, input int b, input int c,
                                input bit en, input bit admit, input bit err,
                                input bit probe, input bit drop0);
        vec_t v;
        v.nl = 3'(nl);
        v.lb[0] = 4'(a);
        v.lb[1] = 4'(b);
        v.lb[2] = 4'(c);
        v.lb[3] = 4'd0;
        v.en = en;
        v.admit = admit;
        v.err = err;
        v.probe = probe;
        v.drop0 = drop0;
        return v;
    endfunction

    task automatic frame_begin();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_end();
        repeat (2) tick();
        cam_vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic send_line(input int nb, input int y, input bit admit, input bit probe);
        logic [7:0] b [16];
        line_seed++;
        for (int i = 0; i < nb; i++) b[i] = 8'(line_seed * 37 + i * 13 + 5);
        if (probe) begin
            b[0] = 8'hF8;
            b[1] = 8'h1F;
        end
        cam_href = 1'b1;
        for (int i = 0; i < nb; i++) begin
            cam_data = b[i];
            if (admit && (i % 2) == 1) exp_q.push_back({b[i-1], b[i], 12'(i / 2), 12'(y)});
            tick();
            if (probe && i == 1) check("lat_before", post_clken, 0);
            if (probe && i == 2) begin
                check("lat_clken", post_clken, 1);
                check("lat_data", post_imgdata, 16'hF81F);
                check("lat_hs", post_hs, 1);
                check("lat_px_x", px_x, 0);
            end
            if (probe && i == 3) check("lat_after", post_clken, 0);
        end
        cam_href = 1'b0;
        cam_data = 8'd0;
        repeat (4) tick();
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        act_q.delete();
        exp_q.delete();
        done_cnt = 0;
        consec_bad = 0;
        hs_bad = 0;
        vs_seen = 1'b0;
        capture_en = v.en;
        frame_begin();
        for (int l = 0; l < int'(v.nl); l++) begin
            send_line(int'(v.lb[l]), l, v.admit, v.probe && l == 0);
            if (v.drop0 && l == 0) capture_en = 1'b0;
        end
        frame_end();
        check("strobe_count", act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("pixel_data_x_y", act_q[i], exp_q[i]);
        check("frame_done_cycles", done_cnt, v.admit);
        check("post_vs_seen", vs_seen, v.admit);
        check("no_back_to_back", consec_bad, 0);
        check("hs_with_clken", hs_bad, 0);
        if (v.admit) check("frame_err", frame_err, v.err);
    endtask

    vec_t tbl [11];

    initial begin
        //            nl  line bytes  en adm err prb drop
        tbl[0]  = mk(2, 8, 8, 0,  1, 0, 0, 0, 0);  // settling frame
        tbl[1]  = mk(2, 8, 8, 0,  1, 1, 0, 0, 0);  // first clean frame
        tbl[2]  = mk(2, 8, 8, 0,  1, 1, 0, 1, 0);  // F8,1F latency probe
        tbl[3]  = mk(2, 8, 7, 0,  1, 1, 1, 0, 0);  // odd byte count
        tbl[4]  = mk(3, 8, 8, 8,  1, 1, 1, 0, 0);  // one line too many
        tbl[5]  = mk(2, 8, 8, 0,  1, 1, 0, 0, 0);  // clean after error
        tbl[6]  = mk(2, 6, 8, 0,  1, 1, 1, 0, 0);  // short line
        tbl[7]  = mk(1, 8, 0, 0,  1, 1, 1, 0, 0);  // one line too few
        tbl[8]  = mk(2, 8, 8, 0,  1, 1, 0, 0, 1);  // enable dropped mid-frame
        tbl[9]  = mk(2, 8, 8, 0,  0, 0, 0, 0, 0);  // disabled at frame start
        tbl[10] = mk(2, 8, 8, 0,  1, 1, 0, 0, 0);  // re-enabled

        line_seed = 0;
        rst = 1'b1;
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        cam_data = 8'd0;
        capture_en = 1'b1;
        repeat (3) tick();
        check("rst_flags", {post_hs, post_vs, post_clken, frame_done, frame_err}, 0);
        check("rst_data", post_imgdata, 0);
        check("rst_xy", {px_x, px_y}, 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int f = 0; f < 11; f++) run_frame(tbl[f]);

        // Reset on the second pixel of an admitted frame.
        capture_en = 1'b1;
        frame_begin();
        cam_href = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cam_data = 8'(i + 1);
            tick();
        end
        check("vs_before_rst", post_vs, 1);
        check("data_before_rst", post_imgdata, 16'h0102);
        rst = 1'b1;
        #1;
        check("rst_async_vs_hs", {post_vs, post_hs}, 0);
        check("rst_async_data", {post_clken, post_imgdata, px_x}, 0);
        tick();
        rst = 1'b0;
        for (int i = 4; i < 8; i++) begin
            cam_data = 8'(i + 1);
            tick();
        end
        cam_href = 1'b0;
        repeat (4) tick();
        frame_end();
        run_frame(mk(2, 8, 8, 0, 1, 0, 0, 0, 0));  // skipped again after reset
        run_frame(mk(2, 8, 8, 0, 1, 1, 0, 0, 0));  // output resumes

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
